pixel_sequencer: RTL
====================

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 2, number of pixel-array rows (>=1).
REQ-002 SHALL have parameter COLUMNS, default 2, number of pixel-array columns (>=1).
REQ-003 SHALL have parameter DATA_W, default 8, bits per pixel sample.
REQ-004 SHALL have parameter ERASE_CYCLES, default 4, erase pulse length in clk cycles (>=1).
REQ-005 SHALL have parameter EXPOSE_CYCLES, default 255, exposure length in clk cycles (>=1).
REQ-006 SHALL have parameter CONVERT_CYCLES, default 255, ADC ramp length in clk cycles (>=1).
REQ-007 Ports: reset reset, synchronous, active-high; clock clk.
REQ-008 SHALL have clk  input  1  rising-edge clock.
REQ-009 SHALL have reset  input  1  synchronous active-high reset.
REQ-010 SHALL have trigger  input  1  start-frame request, sampled in IDLE only.
REQ-011 SHALL have erase  output  1  pixel erase strobe to array.
REQ-012 SHALL have expose  output  1  pixel exposure enable to array.
REQ-013 SHALL have convert  output  1  ADC ramp enable to array.
REQ-014 SHALL have read_row  output  ROWS  one-hot row select to array.
REQ-015 SHALL have pix_data  input  COLUMNS*DATA_W  selected row samples; column c at bits [c*DATA_W +: DATA_W].
REQ-016 SHALL have m_tready  input  1  AXI-Stream downstream ready.
REQ-017 SHALL have m_tvalid  output  1  AXI-Stream valid.
REQ-018 SHALL have m_tdata  output  DATA_W  AXI-Stream pixel sample.
REQ-019 SHALL have m_tlast  output  1  marks final pixel of frame.
REQ-020 SHALL have busy  output  1  high whenever state != IDLE.
REQ-021 SHALL have overrun  output  1  sticky; set when trigger high while busy.

Function
REQ-022 States: IDLE, ERASE, EXPOSE, CONVERT, ROW_SEL, CAPTURE, SEND.
REQ-023 IDLE -> ERASE on cycle trigger=1; otherwise stay.
REQ-024 ERASE: erase=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
REQ-025 EXPOSE: expose=1 for exactly EXPOSE_CYCLES cycles, then CONVERT.
REQ-026 CONVERT: convert=1 for exactly CONVERT_CYCLES cycles, then ROW_SEL with row index r=0.
REQ-027 ROW_SEL: read_row[r]=1 for one settle cycle, then CAPTURE; read_row stays asserted in CAPTURE.
REQ-028 CAPTURE: latch full pix_data into internal row buffer in one cycle, then SEND with column index c=0; read_row=0 from SEND onward.
REQ-029 SEND: m_tvalid=1, m_tdata=buffer column c; c advances only on m_tvalid&&m_tready.
REQ-030 m_tdata and m_tlast SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-031 After transfer of c=COLUMNS-1: if r<ROWS-1 then r+1 and ROW_SEL, else IDLE.
REQ-032 m_tlast=1 only with r=ROWS-1 and c=COLUMNS-1 in SEND.
REQ-033 Exactly ROWS*COLUMNS beats per frame, row-major, column 0 first.
REQ-034 erase/expose/convert/read_row mutually exclusive; at most one asserted per cycle.
REQ-035 Phase counters sized $clog2(max phase)+1; r, c sized $clog2 of ROWS, COLUMNS (min 1 bit); no wrap beyond limits.
REQ-036 trigger while busy SHALL be ignored and SHALL set overrun; overrun clears only on reset.
REQ-037 trigger held high across IDLE return SHALL start the next frame in the cycle after returning to IDLE.
REQ-038 ROWS=1 or COLUMNS=1 SHALL work; ROWS=COLUMNS=1 gives a single beat with m_tlast=1.

Reset
REQ-039 reset=1 SHALL, at next clk edge, force IDLE, all counters 0, erase=expose=convert=0, read_row=0, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, overrun=0, row buffer 0.
REQ-040 reset mid-frame (any state, including SEND with m_tvalid=1) SHALL abort the frame; no further beats issued.

Verification
REQ-041 Defaults, trigger 1 cycle, m_tready=1 -> erase 4, expose 255, convert 255 cycles; 4 beats rows (0,1); m_tlast on beat 4 only.
REQ-042 ROWS=3, COLUMNS=4, pix_data row r column c = 16*r+c -> 12 beats 0x00..0x03,0x10..0x13,0x20..0x23 in order.
REQ-043 m_tready toggling 1-0-1 in SEND -> no lost/duplicated beats; m_tdata stable during stalls.
REQ-044 trigger pulse during EXPOSE -> frame unaffected, overrun=1 until reset.
REQ-045 reset asserted during second SEND beat -> next cycle m_tvalid=0, busy=0, state IDLE; new trigger gives full frame.
REQ-046 ROWS=COLUMNS=1, ERASE/EXPOSE/CONVERT_CYCLES=1 -> trigger to m_tvalid in 6 cycles; one beat, m_tlast=1.

Source files
------------

// File: rtl/pixel_sequencer.sv
// Pixel-array frame sequencer: erase/expose/convert phases, then row-by-row
// readout of the array onto an AXI-Stream master, one sample per beat.
module pixel_sequencer #(
  parameter int ROWS           = 2,
  parameter int COLUMNS        = 2,
  parameter int DATA_W         = 8,
  parameter int ERASE_CYCLES   = 4,
  parameter int EXPOSE_CYCLES  = 255,
  parameter int CONVERT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      trigger,
  output logic                      erase,
  output logic                      expose,
  output logic                      convert,
  output logic [ROWS-1:0]           read_row,
  input  logic [COLUMNS*DATA_W-1:0] pix_data,
  input  logic                      m_tready,
  output logic                      m_tvalid,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tlast,
  output logic                      busy,
  output logic                      overrun
);

  localparam int MAX_EC    = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int MAX_PHASE = (MAX_EC > CONVERT_CYCLES) ? MAX_EC : CONVERT_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PHASE) + 1;
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W     = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;

  localparam logic [CNT_W-1:0] ERASE_LAST   = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXPOSE_LAST  = CNT_W'(EXPOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONVERT_LAST = CNT_W'(CONVERT_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(COLUMNS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    ROW_SEL,
    CAPTURE,
    SEND
  } state_t;

  state_t                    state, state_next;
  logic [CNT_W-1:0]          phase_cnt;
  logic [ROW_W-1:0]          row;
  logic [COL_W-1:0]          col;
  logic [COLUMNS*DATA_W-1:0] row_buf;
  logic                      phase_done;
  logic                      last_row, last_col;

  assign last_row = (row == ROW_LAST);
  assign last_col = (col == COL_LAST);
  assign busy     = (state != IDLE);
  assign m_tdata  = row_buf[col*DATA_W +: DATA_W];

  always_comb begin
    case (state)
      ERASE:   phase_done = (phase_cnt == ERASE_LAST);
      EXPOSE:  phase_done = (phase_cnt == EXPOSE_LAST);
      CONVERT: phase_done = (phase_cnt == CONVERT_LAST);
      default: phase_done = 1'b0;
    endcase
  end

  // NOTE: state and counters update with non-blocking assignments so every
  // register samples the values from before the edge, independent of order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output gets a default before the case statement; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    erase      = 1'b0;
    expose     = 1'b0;
    convert    = 1'b0;
    read_row   = '0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    case (state)
      IDLE:    if (trigger) state_next = ERASE;
      ERASE: begin
        erase = 1'b1;
        if (phase_done) state_next = EXPOSE;
      end
      EXPOSE: begin
        expose = 1'b1;
        if (phase_done) state_next = CONVERT;
      end
      CONVERT: begin
        convert = 1'b1;
        if (phase_done) state_next = ROW_SEL;
      end
      ROW_SEL: begin
        read_row   = ROWS'(1) << row;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        read_row   = ROWS'(1) << row;
        state_next = SEND;
      end
      SEND: begin
        m_tvalid = 1'b1;
        m_tlast  = last_row && last_col;
        if (m_tready && last_col) state_next = last_row ? IDLE : ROW_SEL;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the row buffer is a plain register vector, so it takes the
  // synchronous reset like every other flop and reads back as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt <= '0;
      row       <= '0;
      col       <= '0;
      row_buf   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (busy && trigger) overrun <= 1'b1;

      if (phase_done || !(state inside {ERASE, EXPOSE, CONVERT})) phase_cnt <= '0;
      else                                                       phase_cnt <= phase_cnt + 1'b1;

      case (state)
        IDLE: begin
          row <= '0;
          col <= '0;
        end
        CAPTURE: begin
          row_buf <= pix_data;
          col     <= '0;
        end
        // Column advances only on an accepted beat; row stops at the last one.
        SEND: if (m_tready) begin
          if (last_col) begin
            col <= '0;
            if (!last_row) row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
